// File: rtl/one_hot_decoder_pkg.sv
// Shared constants and the index-to-one-hot helper for the one-hot decoder.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: default widths, helper-function limits, dec_onehot() helper.
package one_hot_decoder_pkg;

    localparam int DEC_IN_WIDTH_DEF  = 3;
    localparam int DEC_OUT_WIDTH_DEF = 8;

    // The helper works on a fixed-width word so it can live outside any
    // parameterised module; callers truncate the result to their OUT_WIDTH.
    localparam int DEC_MAX_IDX_W = 10;
    localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IDX_W;

    // One-hot word with only bit idx set, or all zeros when disabled or when
    // idx is not below width. Never wraps an out-of-range index.
    function automatic logic [DEC_MAX_OUT_W-1:0] dec_onehot(
        input logic                     en,
        input logic [DEC_MAX_IDX_W-1:0] idx,
        input int unsigned              width
    );
        logic [DEC_MAX_OUT_W-1:0] word;
        word = '0;
        if (en && (32'(idx) < width)) begin
            word[idx] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/one_hot_decoder_core.sv
// Combinational decode of (en, data_in) into the next one-hot word (and next oor).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: en, data_in[IN_WIDTH] -> next_data[OUT_WIDTH] (+ next_oor with ONE_HOT_DECODER_OOR_EN).
module one_hot_decoder_core
    import one_hot_decoder_pkg::*;
#(
    parameter int IN_WIDTH  = DEC_IN_WIDTH_DEF,
    parameter int OUT_WIDTH = DEC_OUT_WIDTH_DEF
) (
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  data_in,
`ifdef ONE_HOT_DECODER_OOR_EN
    output logic                 next_oor,
`endif
    output logic [OUT_WIDTH-1:0] next_data
);

    // Reject widths the decoder cannot represent.
    if (IN_WIDTH < 1 || OUT_WIDTH < 1 || OUT_WIDTH > DEC_MAX_OUT_W ||
        (IN_WIDTH < DEC_MAX_IDX_W && OUT_WIDTH > (1 << IN_WIDTH))) begin : g_bad_width
        $fatal(1, "one_hot_decoder: OUT_WIDTH must be in 1..2**IN_WIDTH");
    end

    // OUT_WIDTH <= 2**IN_WIDTH always fits in IN_WIDTH+1 bits.
    localparam logic [IN_WIDTH:0] OUT_LIM = (IN_WIDTH+1)'(OUT_WIDTH);

    // Full-width comparison so no high index bit can alias onto a low output.
    logic above;
    assign above = ({1'b0, data_in} >= OUT_LIM);

    logic [DEC_MAX_IDX_W-1:0] idx;
    if (IN_WIDTH >= DEC_MAX_IDX_W) begin : g_idx_trunc
        // Safe: the function is only enabled when data_in < OUT_WIDTH.
        assign idx = data_in[DEC_MAX_IDX_W-1:0];
    end else begin : g_idx_ext
        assign idx = {{(DEC_MAX_IDX_W-IN_WIDTH){1'b0}}, data_in};
    end

    assign next_data = OUT_WIDTH'(dec_onehot(en && !above, idx, OUT_WIDTH));

`ifdef ONE_HOT_DECODER_OOR_EN
    assign next_oor = en && above;
`endif

endmodule

// File: rtl/one_hot_decoder.sv
// Registered binary-to-one-hot decoder with active-high enable.
// Latency: 1 clk from (en, data_in) to data_out. Backpressure: none, accepts every cycle.
// Ports: clk, rst_n (sync, active low), en, data_in[IN_WIDTH] -> data_out[OUT_WIDTH];
//        optional oor output when ONE_HOT_DECODER_OOR_EN is defined.
module one_hot_decoder
    import one_hot_decoder_pkg::*;
#(
    parameter int IN_WIDTH  = DEC_IN_WIDTH_DEF,
    parameter int OUT_WIDTH = DEC_OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  data_in,
`ifdef ONE_HOT_DECODER_OOR_EN
    output logic                 oor,
`endif
    output logic [OUT_WIDTH-1:0] data_out
);

    logic [OUT_WIDTH-1:0] next_data;
`ifdef ONE_HOT_DECODER_OOR_EN
    logic                 next_oor;
`endif

    one_hot_decoder_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .en        (en),
        .data_in   (data_in),
`ifdef ONE_HOT_DECODER_OOR_EN
        .next_oor  (next_oor),
`endif
        .next_data (next_data)
    );

    // Reset wins over enable; each cycle is decoded independently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= next_data;
        end
    end

`ifdef ONE_HOT_DECODER_OOR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oor <= 1'b0;
        end else begin
            oor <= next_oor;
        end
    end
`endif

endmodule

// File: tb/tb_one_hot_decoder.sv
// Directed-vector bench for one_hot_decoder in three shapes: 3->8, 3->6, 4->16.
// Latency: each vector is driven on the falling edge and checked 1 time unit after the next rising edge.
// Backpressure: none.
module tb_one_hot_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  d8;
    logic [2:0]  d6;
    logic [3:0]  d16;
    logic [7:0]  q8;
    logic [5:0]  q6;
    logic [15:0] q16;
`ifdef ONE_HOT_DECODER_OOR_EN
    logic        oor8;
    logic        oor6;
    logic        oor16;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    one_hot_decoder #(3, 8) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .data_in  (d8),
`ifdef ONE_HOT_DECODER_OOR_EN
        .oor      (oor8),
`endif
        .data_out (q8)
    );

    one_hot_decoder #(3, 6) u_dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .data_in  (d6),
`ifdef ONE_HOT_DECODER_OOR_EN
        .oor      (oor6),
`endif
        .data_out (q6)
    );

    one_hot_decoder #(4, 16) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .data_in  (d16),
`ifdef ONE_HOT_DECODER_OOR_EN
        .oor      (oor16),
`endif
        .data_out (q16)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [2:0]  d8;
        logic [2:0]  d6;
        logic [3:0]  d16;
        logic [7:0]  e8;
        logic [5:0]  e6;
        logic [15:0] e16;
        logic        eoor6;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp_v);
        end
    endtask

    initial begin
        //                rst   en    d8    d6    d16    e8     e6     e16        oor6
        // reset held 3 edges with en=1, data_in=5
        tbl[0]  = '{1'b0, 1'b1, 3'd5, 3'd5, 4'd5,  8'h00, 6'h00, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd5, 3'd5, 4'd5,  8'h00, 6'h00, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd5, 3'd5, 4'd5,  8'h00, 6'h00, 16'h0000, 1'b0};
        // release: first enabled sample shows after the next edge
        tbl[3]  = '{1'b1, 1'b1, 3'd5, 3'd5, 4'd15, 8'h20, 6'h20, 16'h8000, 1'b0};
        // sweep 0..7 then wrap to 0; 3->6 goes out of range at 6 and 7
        tbl[4]  = '{1'b1, 1'b1, 3'd0, 3'd0, 4'd0,  8'h01, 6'h01, 16'h0001, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 3'd1, 3'd1, 4'd1,  8'h02, 6'h02, 16'h0002, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 3'd2, 3'd2, 4'd2,  8'h04, 6'h04, 16'h0004, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 3'd3, 3'd3, 4'd3,  8'h08, 6'h08, 16'h0008, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd4, 3'd4, 4'd4,  8'h10, 6'h10, 16'h0010, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd5, 3'd5, 4'd5,  8'h20, 6'h20, 16'h0020, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'd6, 3'd6, 4'd15, 8'h40, 6'h00, 16'h8000, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 3'd7, 3'd7, 4'd9,  8'h80, 6'h00, 16'h0200, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 3'd0, 3'd0, 4'd0,  8'h01, 6'h01, 16'h0001, 1'b0};
        // enable gating
        tbl[13] = '{1'b1, 1'b0, 3'd3, 3'd3, 4'd3,  8'h00, 6'h00, 16'h0000, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd3, 3'd3, 4'd3,  8'h08, 6'h08, 16'h0008, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 3'd3, 3'd7, 4'd3,  8'h00, 6'h00, 16'h0000, 1'b0};
        // leaves en=1, data_in=6 for the reset-priority sequence below
        tbl[16] = '{1'b1, 1'b1, 3'd6, 3'd6, 4'd6,  8'h40, 6'h00, 16'h0040, 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        d8    = '0;
        d6    = '0;
        d16   = '0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            d8    = tbl[i].d8;
            d6    = tbl[i].d6;
            d16   = tbl[i].d16;
            @(posedge clk);
            #1;
            check($sformatf("row%0d q8", i),  {8'h00, q8},  {8'h00, tbl[i].e8});
            check($sformatf("row%0d q6", i),  {10'h000, q6}, {10'h000, tbl[i].e6});
            check($sformatf("row%0d q16", i), q16, tbl[i].e16);
            check($sformatf("row%0d onehot", i),
                  {13'h0, $onehot0(q8), $onehot0(q6), $onehot0(q16)}, 16'h0007);
`ifdef ONE_HOT_DECODER_OOR_EN
            check($sformatf("row%0d oor6", i), {15'h0, oor6}, {15'h0, tbl[i].eoor6});
            check($sformatf("row%0d oor8", i), {15'h0, oor8}, 16'h0000);
            check($sformatf("row%0d oor16", i), {15'h0, oor16}, 16'h0000);
`endif
        end

        // Reset pulse mid-stream: nothing changes until the edge, then clears.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_not_async q8", {8'h00, q8}, 16'h0040);
        @(posedge clk);
        #1;
        check("rst_pulse q8", {8'h00, q8}, 16'h0000);
        check("rst_pulse q16", q16, 16'h0000);
`ifdef ONE_HOT_DECODER_OOR_EN
        check("rst_pulse oor6", {15'h0, oor6}, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release q8", {8'h00, q8}, 16'h0040);

        // Unknown index while disabled must decode to zero, not X.
        @(negedge clk);
        en  = 1'b0;
        d8  = 3'bxxx;
        d6  = 3'bxxx;
        d16 = 4'bzzzz;
        @(posedge clk);
        #1;
        check("x_dis q8", {8'h00, q8}, 16'h0000);
        check("x_dis q6", {10'h000, q6}, 16'h0000);
        check("x_dis q16", q16, 16'h0000);
`ifdef ONE_HOT_DECODER_OOR_EN
        check("x_dis oor6", {15'h0, oor6}, 16'h0000);
`endif

        // Hold behaviour: output stays put between edges.
        @(negedge clk);
        en  = 1'b1;
        d8  = 3'd2;
        d6  = 3'd7;
        d16 = 4'd15;
        @(posedge clk);
        #1;
        d8 = 3'd4;
        #3;
        check("hold q8", {8'h00, q8}, 16'h0004);
        check("hold q16", q16, 16'h8000);
        check("hold q6", {10'h000, q6}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
